// File: rtl/wishbone_rr_arbiter_pkg.sv
// Shared constants for the Wishbone round-robin arbiter and its helpers.
// Holds the arbiter state encodings.
package wishbone_rr_arbiter_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANTED = 2'd1;
   localparam logic [1:0] ST_ABORT   = 2'd2;

endpackage

// File: rtl/wishbone_rr_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: returns the first set request bit
// found by scanning ptr, ptr+1, ... modulo the vector width.
module rr_priority_picker #(
   parameter int unsigned WIDTH_LOG2 = 1
) (
   input  logic [(1 << WIDTH_LOG2)-1:0] req,
   input  logic [WIDTH_LOG2-1:0]        ptr,
   output logic [WIDTH_LOG2-1:0]        idx,
   output logic                         valid
);

   localparam int unsigned N = 1 << WIDTH_LOG2;

   logic [WIDTH_LOG2-1:0] cand;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = ptr + WIDTH_LOG2'(k);
         if (!valid && req[cand]) begin
            idx   = cand;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin Wishbone classic-cycle arbiter: one owner per CYC burst,
// with a per-transfer watchdog that aborts a slave that never acknowledges.
module wishbone_rr_arbiter
   import wishbone_rr_arbiter_pkg::*;
#(
   parameter int unsigned MASTERS_WIDTH  = 1,
   parameter int unsigned ADDRESS_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [(1 << MASTERS_WIDTH)-1:0]           mCycI,
   input  logic [(1 << MASTERS_WIDTH)-1:0]           mStbI,
   input  logic [(1 << MASTERS_WIDTH)-1:0]           mWeI,
   input  logic [(1 << MASTERS_WIDTH)*ADDRESS_WIDTH-1:0] mAdrIPacked,
   input  logic [(1 << MASTERS_WIDTH)*DATA_WIDTH-1:0]    mDatIPacked,
   output logic [(1 << MASTERS_WIDTH)*DATA_WIDTH-1:0]    mDatOPacked,
   output logic [(1 << MASTERS_WIDTH)-1:0]           mAckO,
   output logic [(1 << MASTERS_WIDTH)-1:0]           mErrO,
   output logic                                      sCycO,
   output logic                                      sStbO,
   output logic                                      sWeO,
   output logic [ADDRESS_WIDTH-1:0]                  sAdrO,
   output logic [DATA_WIDTH-1:0]                     sDatO,
   input  logic                                      sAckI,
   input  logic [DATA_WIDTH-1:0]                     sDatI
);

   localparam int unsigned N     = 1 << MASTERS_WIDTH;
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   logic [1:0]               state_q, state_d;
   logic [MASTERS_WIDTH-1:0] owner_q, owner_d;
   logic [MASTERS_WIDTH-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;

   logic                     owner_cyc, active, timeout;
   logic [MASTERS_WIDTH-1:0] pick_ptr, pick_idx;
   logic                     pick_valid;

   assign owner_cyc = mCycI[owner_q];
   assign active    = (state_q == ST_GRANTED) && owner_cyc;
   assign timeout   = (TIMEOUT_CYCLES != 0) && active && sStbO && !sAckI && (cnt_q == CNT_LAST);

   // On release the hand-over scan already starts past the old owner.
   assign pick_ptr = (state_q == ST_GRANTED) ? owner_q + MASTERS_WIDTH'(1) : ptr_q;

   rr_priority_picker #(
      .WIDTH_LOG2 (MASTERS_WIDTH)
   ) u_picker (
      .req   (mCycI),
      .ptr   (pick_ptr),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d = ST_GRANTED;
               owner_d = pick_idx;
            end
         end
         ST_GRANTED: begin
            if (owner_cyc) begin
               if (timeout) begin
                  state_d = ST_ABORT;
               end else if ((TIMEOUT_CYCLES != 0) && sStbO && !sAckI) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               ptr_d = owner_q + MASTERS_WIDTH'(1);
               if (pick_valid) begin
                  owner_d = pick_idx;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_ABORT: begin
            if (!owner_cyc) begin
               ptr_d   = owner_q + MASTERS_WIDTH'(1);
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      sCycO = 1'b0;
      sStbO = 1'b0;
      sWeO  = 1'b0;
      sAdrO = '0;
      sDatO = '0;
      mAckO = '0;
      mErrO = '0;
      if (active) begin
         sCycO          = 1'b1;
         sStbO          = mStbI[owner_q];
         sWeO           = mWeI[owner_q];
         sAdrO          = mAdrIPacked[owner_q*ADDRESS_WIDTH +: ADDRESS_WIDTH];
         sDatO          = mDatIPacked[owner_q*DATA_WIDTH +: DATA_WIDTH];
         mAckO[owner_q] = sAckI;
         mErrO[owner_q] = timeout;
      end
   end

   assign mDatOPacked = {N{sDatI}};

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Self-checking bench for wishbone_rr_arbiter (2 masters, 8-cycle watchdog):
// directed scenarios plus random traffic against a behavioural model.
module tb_wishbone_rr_arbiter;

   localparam int MW = 1;
   localparam int N  = 2;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int TO = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    m_cyc, m_stb, m_we, m_ack_o, m_err_o;
   logic [N*AW-1:0] m_adr;
   logic [N*DW-1:0] m_dat, m_dat_o;
   logic            s_cyc_o, s_stb_o, s_we_o, s_ack;
   logic [AW-1:0]   s_adr_o;
   logic [DW-1:0]   s_dat_o, s_dat;

   always #5 clk = ~clk;

   wishbone_rr_arbiter #(
      .MASTERS_WIDTH  (MW),
      .ADDRESS_WIDTH  (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mCycI       (m_cyc),
      .mStbI       (m_stb),
      .mWeI        (m_we),
      .mAdrIPacked (m_adr),
      .mDatIPacked (m_dat),
      .mDatOPacked (m_dat_o),
      .mAckO       (m_ack_o),
      .mErrO       (m_err_o),
      .sCycO       (s_cyc_o),
      .sStbO       (s_stb_o),
      .sWeO        (s_we_o),
      .sAdrO       (s_adr_o),
      .sDatO       (s_dat_o),
      .sAckI       (s_ack),
      .sDatI       (s_dat)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: who owns the bus, whether it is being aborted,
   // who has priority next, and how long the current strobe has stalled.
   bit mdl_busy, mdl_abort;
   int mdl_owner, mdl_next, mdl_wait;
   bit exp_timeout, exp_stall;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int first_requester(input logic [N-1:0] cyc, input int from);
      for (int k = 0; k < N; k++) begin
         if (cyc[(from + k) % N]) return (from + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      mdl_busy  = 1'b0;
      mdl_abort = 1'b0;
      mdl_owner = 0;
      mdl_next  = 0;
      mdl_wait  = 0;
   endtask

   // Let inputs settle (optionally acting as a zero-wait slave), then compare all outputs.
   task automatic settle(input string tag, input bit zero_wait);
      logic [N-1:0]  e_ack, e_err;
      logic          e_cyc, e_stb, e_we;
      logic [AW-1:0] e_adr;
      logic [DW-1:0] e_dat;
      bit            serving;
      #1;
      if (zero_wait) s_ack = s_stb_o & s_cyc_o;
      #1;
      e_ack = '0; e_err = '0; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0;
      serving     = mdl_busy && !mdl_abort && m_cyc[mdl_owner];
      exp_timeout = 1'b0;
      exp_stall   = 1'b0;
      if (serving) begin
         e_cyc            = 1'b1;
         e_stb            = m_stb[mdl_owner];
         e_we             = m_we[mdl_owner];
         e_adr            = m_adr[mdl_owner*AW +: AW];
         e_dat            = m_dat[mdl_owner*DW +: DW];
         e_ack[mdl_owner] = s_ack;
         exp_stall        = e_stb && !s_ack;
         exp_timeout      = exp_stall && (mdl_wait == TO - 1);
         e_err[mdl_owner] = exp_timeout;
      end
      check({tag, ".sCycO"}, s_cyc_o, e_cyc);
      check({tag, ".sStbO"}, s_stb_o, e_stb);
      check({tag, ".sWeO"},  s_we_o,  e_we);
      check({tag, ".sAdrO"}, s_adr_o, e_adr);
      check({tag, ".sDatO"}, s_dat_o, e_dat);
      check({tag, ".mAckO"}, m_ack_o, e_ack);
      check({tag, ".mErrO"}, m_err_o, e_err);
      check({tag, ".mDatO"}, m_dat_o, {N{s_dat}});
   endtask

   // Advance one clock and apply the arbitration rules to the model.
   task automatic tick();
      int r;
      @(posedge clk);
      if (mdl_abort) begin
         if (!m_cyc[mdl_owner]) begin
            mdl_abort = 1'b0;
            mdl_busy  = 1'b0;
            mdl_next  = (mdl_owner + 1) % N;
         end
      end else if (mdl_busy) begin
         if (m_cyc[mdl_owner]) begin
            if (exp_timeout) begin
               mdl_abort = 1'b1;
               mdl_wait  = 0;
            end else begin
               mdl_wait = exp_stall ? mdl_wait + 1 : 0;
            end
         end else begin
            mdl_next = (mdl_owner + 1) % N;
            mdl_wait = 0;
            r = first_requester(m_cyc, mdl_next);
            if (r < 0) mdl_busy = 1'b0;
            else       mdl_owner = r;
         end
      end else begin
         r = first_requester(m_cyc, mdl_next);
         if (r >= 0) begin
            mdl_busy  = 1'b1;
            mdl_owner = r;
            mdl_wait  = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic step(input string tag, input bit zero_wait);
      settle(tag, zero_wait);
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst.sCycO", s_cyc_o, 1'b0);
      check("rst.sStbO", s_stb_o, 1'b0);
      check("rst.sWeO",  s_we_o,  1'b0);
      check("rst.sAdrO", s_adr_o, '0);
      check("rst.sDatO", s_dat_o, '0);
      check("rst.mAckO", m_ack_o, '0);
      check("rst.mErrO", m_err_o, '0);
      check("rst.mDatO", m_dat_o, {N{s_dat}});
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int ack_pct;
      rst = 1'b1;
      m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;
      s_ack = 1'b0; s_dat = 16'h5A5A;
      model_reset();
      @(negedge clk);
      do_reset();
      step("idle0", 1'b0);

      // Single master write with a zero-wait slave.
      m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01;
      m_adr = {16'h0000, 16'h0042}; m_dat = {16'h0000, 16'h1234};
      settle("sm.req", 1'b1);
      check("sm.req.cyc_latency", s_cyc_o, 1'b0);
      tick();
      settle("sm.gnt", 1'b1);
      check("sm.gnt.cyc",  s_cyc_o, 1'b1);
      check("sm.gnt.adr",  s_adr_o, 16'h0042);
      check("sm.gnt.dat",  s_dat_o, 16'h1234);
      check("sm.gnt.ack",  m_ack_o, 2'b01);
      tick();
      m_cyc = '0; m_stb = '0; m_we = '0;
      step("sm.rel", 1'b1);
      step("sm.idle", 1'b1);

      // Contention: alternation over 8 rounds, hand-over without an idle cycle.
      do_reset();
      m_adr = {16'h0200, 16'h0100}; m_dat = {16'hBBBB, 16'hAAAA};
      m_stb = 2'b11; m_we = 2'b10; m_cyc = 2'b11;
      step("ct.req", 1'b1);
      for (int r = 0; r < 8; r++) begin
         settle($sformatf("ct.r%0d", r), 1'b1);
         check($sformatf("ct.r%0d.owner_adr", r), s_adr_o, (r % 2) ? 16'h0200 : 16'h0100);
         check($sformatf("ct.r%0d.cyc", r), s_cyc_o, 1'b1);
         tick();
         step($sformatf("ct.r%0d.hold", r), 1'b1);
         m_cyc[r % 2] = 1'b0;
         step($sformatf("ct.r%0d.rel", r), 1'b1);
         m_cyc = 2'b11;
      end

      // Burst hold: master 1 keeps the bus for 5 reads while master 0 waits.
      m_cyc = '0; m_stb = '0;
      step("bh.idle", 1'b0);
      m_cyc = 2'b10; m_stb = 2'b10; m_we = '0; s_dat = 16'h00A5;
      step("bh.req", 1'b1);
      m_cyc = 2'b11; m_stb = 2'b11;
      for (int i = 0; i < 5; i++) begin
         settle($sformatf("bh.rd%0d", i), 1'b1);
         check($sformatf("bh.rd%0d.ack", i), m_ack_o, 2'b10);
         check($sformatf("bh.rd%0d.rdata", i), m_dat_o[31:16], 16'h00A5);
         tick();
      end
      m_cyc = 2'b01;
      step("bh.rel", 1'b1);
      settle("bh.m0", 1'b1);
      check("bh.m0.adr", s_adr_o, 16'h0100);
      tick();
      m_cyc = '0; m_stb = '0;
      step("bh.end", 1'b0);

      // Watchdog: slave never acknowledges master 0.
      do_reset();
      s_ack = 1'b0; m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01;
      step("to.req", 1'b0);
      for (int i = 0; i < 8; i++) begin
         settle($sformatf("to.stall%0d", i), 1'b0);
         check($sformatf("to.stall%0d.err", i), m_err_o, (i == 7) ? 2'b01 : 2'b00);
         tick();
      end
      m_cyc = 2'b11; m_stb = 2'b11;
      for (int i = 0; i < 3; i++) begin
         settle($sformatf("to.abort%0d", i), 1'b0);
         check($sformatf("to.abort%0d.cyc", i), s_cyc_o, 1'b0);
         tick();
      end
      m_cyc = 2'b10;
      step("to.drop", 1'b0);
      step("to.idle", 1'b0);
      settle("to.m1", 1'b0);
      check("to.m1.adr", s_adr_o, 16'h0200);
      tick();
      // ACK arriving in the would-be timeout cycle wins.
      for (int i = 1; i < 8; i++) begin
         if (i == 7) s_ack = 1'b1;
         settle($sformatf("to.ack%0d", i), 1'b0);
         if (i == 7) begin
            check("to.ackwin.err", m_err_o, 2'b00);
            check("to.ackwin.ack", m_ack_o, 2'b10);
         end
         tick();
      end
      s_ack = 1'b0; m_cyc = '0; m_stb = '0;
      step("to.end", 1'b0);
      step("to.end2", 1'b0);

      // Random traffic in blocks of differing slave responsiveness.
      do_reset();
      for (int blk = 0; blk < 9; blk++) begin
         ack_pct = (blk % 3 == 0) ? 0 : ((blk % 3 == 1) ? 30 : 80);
         for (int i = 0; i < 50; i++) begin
            for (int m = 0; m < N; m++) begin
               if ($urandom_range(3) == 0) m_cyc[m] = ~m_cyc[m];
               m_stb[m] = ($urandom_range(7) != 0);
            end
            m_we  = N'($urandom_range(3));
            m_adr = N*AW'($urandom);
            m_dat = N*DW'($urandom);
            s_dat = DW'($urandom);
            s_ack = ($urandom_range(99) < ack_pct);
            step("rnd", 1'b0);
         end
      end

      // Reset asserted between edges while master 1 owns the bus.
      do_reset();
      m_adr = {16'h0200, 16'h0100}; m_dat = {16'hBBBB, 16'hAAAA};
      m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10; s_ack = 1'b0;
      step("rm.req", 1'b0);
      settle("rm.own", 1'b0);
      check("rm.own.stb", s_stb_o, 1'b1);
      s_ack = 1'b1;
      #1 rst = 1'b1;
      #1;
      check("rm.async.cyc", s_cyc_o, 1'b0);
      check("rm.async.stb", s_stb_o, 1'b0);
      check("rm.async.ack", m_ack_o, 2'b00);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      s_ack = 1'b0; m_cyc = 2'b11; m_stb = 2'b11;
      step("rm.req2", 1'b0);
      settle("rm.gnt", 1'b0);
      check("rm.gnt.m0", s_adr_o, 16'h0100);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
